// File: rtl/led_step_controller.sv
// Step-strobe sequencer for the LED colour block: manual, auto and burst modes.
// Optional COLOUR_MIRROR_EN adds a colour_mirror output tracking the LED colour.
module led_step_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DWELL_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               button_raw,
    input  logic [1:0]         mode_sel,
    input  logic               start,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [2:0]         burst_len,
    output logic               step,
    output logic [1:0]         state,
    output logic               burst_done
`ifdef COLOUR_MIRROR_EN
    ,
    output logic [2:0]         colour_mirror
`endif
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        MANUAL = 2'b01,
        AUTO   = 2'b10,
        BURST  = 2'b11
    } state_t;

    state_t             st, st_n;
    logic               sync1, btn_s;
    logic               btn_db, btn_db_q;
    logic [DBW-1:0]     db_cnt;
    logic               press;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [3:0]         rem, rem_n;
    logic               step_n;
    logic               fin, fin_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            btn_s    <= 1'b0;
            btn_db   <= 1'b0;
            btn_db_q <= 1'b0;
            db_cnt   <= '0;
        end else begin
            sync1    <= button_raw;
            btn_s    <= sync1;
            btn_db_q <= btn_db;
            if (btn_s == btn_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                btn_db <= btn_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DBW'(1);
            end
        end
    end

    assign press = btn_db & ~btn_db_q;

    always_comb begin
        st_n   = st;
        cnt_n  = cnt;
        rem_n  = rem;
        step_n = 1'b0;
        fin_n  = 1'b0;
        case (st)
            IDLE: begin
                case (mode_sel)
                    2'b01: st_n = MANUAL;
                    2'b10: begin
                        st_n  = AUTO;
                        cnt_n = dwell;
                    end
                    2'b11: begin
                        if (start) begin
                            st_n  = BURST;
                            cnt_n = dwell;
                            rem_n = (burst_len == 3'd0) ? 4'd8 : {1'b0, burst_len};
                        end
                    end
                    default: st_n = IDLE;
                endcase
            end
            MANUAL: begin
                if (mode_sel != 2'b01) st_n = IDLE;
                else step_n = press;
            end
            AUTO: begin
                // holding the button pauses the dwell count
                if (mode_sel != 2'b10) begin
                    st_n = IDLE;
                end else if (!btn_db) begin
                    if (cnt != '0) begin
                        cnt_n = cnt - DWELL_W'(1);
                    end else begin
                        step_n = 1'b1;
                        cnt_n  = dwell;
                    end
                end
            end
            BURST: begin
                if (mode_sel != 2'b11) begin
                    st_n = IDLE;
                end else if (cnt != '0) begin
                    cnt_n = cnt - DWELL_W'(1);
                end else begin
                    step_n = 1'b1;
                    cnt_n  = dwell;
                    rem_n  = rem - 4'd1;
                    if (rem == 4'd1) begin
                        st_n  = IDLE;
                        fin_n = 1'b1;
                    end
                end
            end
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= IDLE;
            cnt        <= '0;
            rem        <= '0;
            step       <= 1'b0;
            fin        <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            st         <= st_n;
            cnt        <= cnt_n;
            rem        <= rem_n;
            step       <= step_n;
            fin        <= fin_n;
            burst_done <= fin;
        end
    end

    assign state = st;

`ifdef COLOUR_MIRROR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colour_mirror <= 3'd1;
        end else if (step) begin
            colour_mirror <= (colour_mirror == 3'd6) ? 3'd1 : colour_mirror + 3'd1;
        end
    end
`endif

endmodule

// File: tb/tb_led_step_controller.sv
// Self-checking bench for led_step_controller: vector table plus
// hand sequences; expected step/burst_done cycles go through queues.
module tb_led_step_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       button_raw = 1'b0;
    logic [1:0] mode_sel = 2'b00;
    logic       start = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [2:0] burst_len = 3'd0;
    logic       step;
    logic [1:0] state;
    logic       burst_done;
`ifdef COLOUR_MIRROR_EN
    logic [2:0] colour_mirror;
`endif

    led_step_controller #(
        .DEBOUNCE_CYCLES(4),
        .DWELL_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .button_raw(button_raw),
        .mode_sel(mode_sel),
        .start(start),
        .dwell(dwell),
        .burst_len(burst_len),
        .step(step),
        .state(state),
        .burst_done(burst_done)
`ifdef COLOUR_MIRROR_EN
        ,
        .colour_mirror(colour_mirror)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int done_q[$];
    bit mon_en = 1'b0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // scoreboard: each observed strobe consumes the oldest expected cycle
    always @(negedge clk) begin
        if (mon_en && step) begin
            if (exp_q.size() == 0) chk("step_unexpected", cyc, -1);
            else chk("step_cycle", cyc, exp_q.pop_front());
        end
        if (mon_en && burst_done) begin
            if (done_q.size() == 0) chk("done_unexpected", cyc, -1);
            else chk("done_cycle", cyc, done_q.pop_front());
        end
    end

    // return at the negedge just before edge k, so drives land on edge k
    task automatic go(input int k);
        while (cyc < k - 1) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        mode_sel   = 2'b00;
        start      = 1'b0;
        button_raw = 1'b0;
        rst_n      = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [1:0] mode;
        int dwell;
        int blen;
        int run;
        int n;
        int per;
        int done;
    } vec_t;

    vec_t vt[7];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e;
        int k;
        int ctab[7];

        vt[0] = '{2'b10, 3, 0, 20, 4, 4, 0};
        vt[1] = '{2'b10, 0, 0, 6, 5, 1, 0};
        vt[2] = '{2'b10, 7, 0, 17, 2, 8, 0};
        vt[3] = '{2'b11, 2, 5, 40, 5, 3, 1};
        vt[4] = '{2'b11, 0, 0, 40, 8, 1, 1};
        vt[5] = '{2'b11, 1, 1, 40, 1, 2, 1};
        vt[6] = '{2'b11, 2, 5, 8, 2, 3, 0};
        ctab = '{2, 3, 4, 5, 6, 1, 2};

        // reset state
        @(negedge clk);
        chk("rst_step", int'(step), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_done", int'(burst_done), 0);
`ifdef COLOUR_MIRROR_EN
        chk("rst_colour", int'(colour_mirror), 1);
`endif
        rst_n = 1'b1;

        // asynchronous reset in the middle of a dwell-0 burst, button held
        e = cyc + 3;
        go(e);
        mode_sel = 2'b11; dwell = 8'd0; burst_len = 3'd0;
        start = 1'b1; button_raw = 1'b1;
        go(e + 1);
        start = 1'b0;
        go(e + 3);
        chk("burst_running", int'(step), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_step", int'(step), 0);
        chk("async_rst_state", int'(state), 0);
        chk("async_rst_done", int'(burst_done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        go(cyc + 6);
        chk("post_rst_idle", int'(state), 0);
        button_raw = 1'b0;
        mode_sel = 2'b00;
        go(cyc + 12);
        mon_en = 1'b1;

        // table of auto/burst vectors
        foreach (vt[i]) begin
            do_reset();
            e = cyc + 3;
            go(e);
            mode_sel  = vt[i].mode;
            dwell     = 8'(vt[i].dwell);
            burst_len = 3'(vt[i].blen);
            start     = (vt[i].mode == 2'b11);
            for (int j = 1; j <= vt[i].n; j++) exp_q.push_back(e + vt[i].per * j);
            if (vt[i].done != 0) done_q.push_back(e + vt[i].per * vt[i].n + 1);
            go(e + 1);
            start = 1'b0;
            chk($sformatf("v%0d_state", i), int'(state), int'(vt[i].mode));
            if (vt[i].mode == 2'b11) begin
                go(e + 2);
                start = 1'b1;
                go(e + 3);
                start = 1'b0;
            end
            go(e + vt[i].run);
            mode_sel = 2'b00;
            go(e + vt[i].run + 1);
            chk($sformatf("v%0d_exit_state", i), int'(state), 0);
            go(e + vt[i].run + 6);
            chk($sformatf("v%0d_steps_left", i), exp_q.size(), 0);
            chk($sformatf("v%0d_done_left", i), done_q.size(), 0);
            exp_q.delete();
            done_q.delete();
        end

        // manual: debounced press gives one step, 3-cycle glitch gives none
        do_reset();
        e = cyc + 3;
        go(e);
        mode_sel = 2'b01;
        go(e + 1);
        chk("man_state", int'(state), 1);
        k = e + 5;
        go(k);
        button_raw = 1'b1;
        exp_q.push_back(k + 6);
        go(k + 20);
        button_raw = 1'b0;
        go(k + 40);
        button_raw = 1'b1;
        go(k + 43);
        button_raw = 1'b0;
        go(k + 60);
        chk("man_steps_left", exp_q.size(), 0);
        mode_sel = 2'b00;
        go(k + 62);
        chk("man_exit_state", int'(state), 0);
        exp_q.delete();

        // auto pause-while-held: count freezes at 1, resumes after release
        do_reset();
        e = cyc + 3;
        go(e);
        mode_sel = 2'b10; dwell = 8'd3;
        exp_q.push_back(e + 4);
        exp_q.push_back(e + 8);
        exp_q.push_back(e + 12);
        exp_q.push_back(e + 26);
        exp_q.push_back(e + 30);
        go(e + 9);
        button_raw = 1'b1;
        go(e + 19);
        button_raw = 1'b0;
        go(e + 32);
        mode_sel = 2'b00;
        go(e + 40);
        chk("pause_steps_left", exp_q.size(), 0);
        chk("pause_exit_state", int'(state), 0);
        exp_q.delete();

`ifdef COLOUR_MIRROR_EN
        do_reset();
        chk("colour_init", int'(colour_mirror), 1);
        e = cyc + 3;
        go(e);
        mode_sel = 2'b01;
        for (int i = 0; i < 7; i++) begin
            k = e + 5 + i * 20;
            go(k);
            button_raw = 1'b1;
            exp_q.push_back(k + 6);
            go(k + 10);
            button_raw = 1'b0;
            go(k + 19);
            chk($sformatf("colour_%0d", i), int'(colour_mirror), ctab[i]);
        end
        chk("colour_steps_left", exp_q.size(), 0);
        mode_sel = 2'b00;
        exp_q.delete();
`endif

        go(cyc + 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led_step_controller.md
Name: led_step_controller

Overview:
- Sequencer for the dynamic LED colour block: generates that block's single-cycle step strobe (drives its button input).
- Three operating modes: manual (debounced push-button), auto (periodic step at programmable dwell) and burst (N steps then stop).
- Sits between the board push-button/mode switches and the LED colour block; one instance per LED colour block.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronised samples needed to accept a new button level (>=1).
- DWELL_W, 8, width of the dwell value and dwell counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- button_raw  in  1  raw asynchronous push-button, active-high
- mode_sel  in  2  00 OFF, 01 MANUAL, 10 AUTO, 11 BURST
- start  in  1  synchronous pulse; launches a burst when mode_sel=11 in IDLE
- dwell  in  DWELL_W  idle cycles between auto/burst steps
- burst_len  in  3  steps per burst; 0 means 8
- step  out  1  registered one-cycle strobe to the LED colour block
- state  out  2  00 IDLE, 01 MANUAL, 10 AUTO, 11 BURST
- burst_done  out  1  registered one-cycle pulse on burst completion

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, step=0, burst_done=0, synchroniser flops=0, btn_db=0, debounce count=0, dwell counter=0, remaining=0.
- Input conditioning: button_raw -> 2-flop synchroniser -> btn_s. Debounce: if btn_s != btn_db, count increments; when count reaches DEBOUNCE_CYCLES, btn_db<=btn_s and count clears; if btn_s == btn_db, count clears. press = btn_db rising edge (one cycle).
- Latency: raw rising edge sampled at edge k -> btn_db high after edge k+1+DEBOUNCE_CYCLES -> step high for exactly one cycle after edge k+2+DEBOUNCE_CYCLES (MANUAL).
- IDLE: step=0. mode_sel=01 -> MANUAL; 10 -> AUTO (dwell counter loaded with dwell); 11 and start=1 -> BURST (counter loaded with dwell, remaining=burst_len, 0 maps to 8). 00, or 11 without start: stay.
- MANUAL: step<=press. mode_sel!=01 -> IDLE next edge; a press arriving in the exit cycle is dropped.
- AUTO: if btn_db=1, counter frozen and no step (pause-while-held). Else counter!=0 decrements; counter==0 -> step<=1 and counter reloads with current dwell. Step period is dwell+1 cycles; dwell=0 steps every cycle. mode_sel!=10 -> IDLE, no step issued on the exit edge.
- BURST: same dwell timing as AUTO, button ignored. Each step decrements remaining; on the edge issuing the final step, state -> IDLE; burst_done=1 on the following cycle only. mode_sel!=11 mid-burst aborts -> IDLE, no further step, no burst_done. start while in BURST is ignored (no retrigger).
- dwell/burst_len are sampled only on load/reload; changes mid-period take effect at next reload.
- step and burst_done are never high for two consecutive cycles, except step in AUTO/BURST with dwell=0.
- Reset mid-operation: outputs clear immediately (asynchronously); any burst in progress is lost.

Optional Feature:
- Macro COLOUR_MIRROR_EN.
- Defined: extra output colour_mirror[2:0] models the LED block's colour. Reset value 3'b001; on each step 1->2->...->6->1 (0 and 7 never appear). Used for on-board status display.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset: rst_n low mid-cycle with button held -> step=0, state=00, burst_done=0 immediately; after release state=00 until mode_sel changes.
- MANUAL debounce: DEBOUNCE_CYCLES=4, mode_sel=01, button_raw high at edge 10 for 20 cycles -> single step at cycle after edge 16; a 3-cycle glitch -> no step.
- AUTO: mode_sel=10, dwell=3 -> step every 4 cycles; hold button 10 cycles -> steps stop and resume with the frozen count; dwell=0 -> step every cycle.
- BURST: mode_sel=11, dwell=2, burst_len=5, start pulse -> exactly 5 steps 3 cycles apart, burst_done one cycle after 5th step, state=00; burst_len=0 -> 8 steps.
- BURST abort: mode_sel 11->00 after 2 steps -> no more steps, burst_done stays 0, state=00 next cycle.
- COLOUR_MIRROR_EN: 7 manual steps from reset -> colour_mirror 1,2,3,4,5,6,1,2.
